dispense_sequencer: RTL and testbench
=====================================

DISPENSE_SEQUENCER -- requirements
Module: dispense_sequencer

Interface
REQ-001 Parameter STEP_HALF, default 4: clock cycles per high phase and per low phase of a normal-rate stepper pulse.
REQ-002 Parameter STEP_HALF_FAST, default 2: clock cycles per high phase and per low phase of a fast-rate stepper pulse.
REQ-003 Parameter SPINUP_CYC, default 16: DC spin-up cycles before stepping starts.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 disp  in  1  dispense request; a rising edge starts one dispense.
REQ-007 amount  in  2  dispense size select.
REQ-008 test  in  3  manual test-mode select.
REQ-009 handshake  out  1  dispense complete.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 stepper_dir  out  1  stepper direction: 0 = clockwise, 1 = counter-clockwise.
REQ-012 stepper_step  out  1  stepper pulse train.
REQ-013 dc_pwm  out  1  DC motor PWM enable.
REQ-014 dc_in1, dc_in2  out  1 each  DC direction: 0/1 = clockwise, 1/0 = counter-clockwise.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 States: IDLE, SPINUP, STEP, DONE, TEST.
REQ-017 PWM generation:
- 8-bit free-running PWM counter.
- dc_pwm = (counter < duty).
- duty is one of 0, 64, 128, 192 (0 / 25 / 50 / 75 %).
- duty 0 SHALL give dc_pwm constantly low.
REQ-018 IDLE outputs: duty 0, stepper_step 0, stepper_dir 0, dc_in1 0, dc_in2 1, handshake 0.
REQ-019 disp is edge-detected against its previous-cycle sample.
REQ-020 IDLE -> SPINUP on a disp rising edge; amount is latched on the same edge.
REQ-021 disp rising has priority over a nonzero test value.
REQ-022 Step count from latched amount: 00 -> 100, 01 -> 200, 10 -> 300, 11 -> 100. Count register is 9 bits.
REQ-023 SPINUP: duty 128, clockwise, for exactly SPINUP_CYC cycles, then -> STEP.
REQ-024 STEP:
- duty 128 held.
- Each pulse is STEP_HALF cycles high then STEP_HALF cycles low.
- A pulse is counted at the end of its low phase.
- After the Nth pulse -> DONE, so STEP lasts exactly N*2*STEP_HALF cycles.
REQ-025 DONE: duty 0, stepper_step 0, handshake 1; remain in DONE while disp = 1; -> IDLE on the first cycle disp = 0.
REQ-026 DONE SHALL hold handshake high for at least one cycle even if disp is already low on entry.
REQ-027 The following SHALL have no effect until DONE is reached:
- disp falling during SPINUP or STEP;
- changes on amount or test during SPINUP or STEP.
REQ-028 Latency: disp sampled high at edge k -> busy = 1 and dc_pwm duty active from the cycle after edge k.
REQ-029 IDLE -> TEST when test is not in {000, 111} and no disp rising edge is present.
REQ-030 TEST modes:
- 001: stepper normal rate, clockwise.
- 010: stepper normal rate, counter-clockwise.
- 011: stepper fast rate, clockwise.
- 100: DC duty 64, clockwise.
- 101: DC duty 64, counter-clockwise.
- 110: DC duty 192, clockwise.
REQ-031 TEST repeats its pulses indefinitely and ignores disp.
REQ-032 Any change of the test value while in TEST SHALL force -> IDLE for exactly one cycle (all outputs idle) before re-entering TEST. stepper_dir therefore never changes while stepper_step = 1.
REQ-033 The step phase counter SHALL restart at the beginning of the high phase on every entry to STEP or TEST.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and clear all counters and the disp edge register.
REQ-035 During and after reset: handshake 0, busy 0, stepper_step 0, stepper_dir 0, dc_pwm 0, dc_in1 0, dc_in2 1.
REQ-036 Reset asserted mid-dispense SHALL abort the dispense, with no handshake, and restart from IDLE.

Verification (defaults STEP_HALF = 4, STEP_HALF_FAST = 2, SPINUP_CYC = 16)
REQ-037 amount = 00, disp pulsed high and held -> 16 SPINUP cycles, then 100 step pulses of 8 cycles each (800 cycles), then handshake = 1 until disp drops, then handshake = 0 on the next cycle.
REQ-038 amount = 10 and disp raised, then amount changed to 00 and disp dropped during STEP -> exactly 300 pulses, then handshake high for one cycle, then IDLE.
REQ-039 test = 010 -> stepper_dir 1 with a continuous 8-cycle pulse train; switch to 011 -> one idle cycle, then dir 0 with a 4-cycle pulse train; stepper_dir never toggles while stepper_step is high.
REQ-040 test = 110 -> dc_pwm high for 192 of every 256 cycles with dc_in1/dc_in2 = 0/1; test = 101 -> 64 of 256 cycles with 1/0.
REQ-041 rst_n pulsed low at pulse 50 of an amount = 01 dispense -> outputs idle immediately, no handshake; a new disp edge gives a full 200-pulse dispense.
REQ-042 disp rising and test = 100 in the same cycle while IDLE -> dispense runs; TEST is entered only after DONE -> IDLE.

Source files
------------

// File: rtl/dispense_sequencer.sv
// Dispense sequencer: spins a DC motor up, then steps a stepper motor a
// selected number of pulses, then handshakes. A manual TEST mode drives
// the stepper or DC motor continuously for bench bring-up.
//
// Handshake semantics: disp is a request level whose rising edge starts one
// dispense; handshake is held high in DONE until disp is seen low, so the
// requester owns the end of the transaction.
module dispense_sequencer #(
   parameter int STEP_HALF      = 4,
   parameter int STEP_HALF_FAST = 2,
   parameter int SPINUP_CYC     = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       disp,
   input  logic [1:0] amount,
   input  logic [2:0] test,
   output logic       handshake,
   output logic       busy,
   output logic       stepper_dir,
   output logic       stepper_step,
   output logic       dc_pwm,
   output logic       dc_in1,
   output logic       dc_in2,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SPINUP = 3'd1,
      STEP   = 3'd2,
      DONE   = 3'd3,
      TEST   = 3'd4
   } state_t;

   localparam logic [15:0] HALF_N    = 16'(STEP_HALF);
   localparam logic [15:0] HALF_F    = 16'(STEP_HALF_FAST);
   localparam logic [15:0] LAST_N    = 16'(2 * STEP_HALF - 1);
   localparam logic [15:0] LAST_F    = 16'(2 * STEP_HALF_FAST - 1);
   localparam logic [15:0] SPIN_LAST = 16'(SPINUP_CYC - 1);

   state_t      state, state_nxt;
   logic [15:0] phase, phase_nxt;
   logic [8:0]  pulse, pulse_nxt;
   logic [8:0]  steps, steps_nxt;
   logic [2:0]  mode, mode_nxt;
   logic        disp_q;
   logic        disp_rise;
   logic [7:0]  pwm_cnt;
   logic [7:0]  duty_nxt;
   logic        step_nxt, dir_nxt, in1_nxt, in2_nxt, hs_nxt;
   logic [15:0] test_last;

   assign disp_rise = disp & ~disp_q;
   assign state_dbg = state;
   assign test_last = (mode == 3'b011) ? LAST_F : LAST_N;

   // Next-state logic: phase counter, pulse counter and latched selections.
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      pulse_nxt = pulse;
      steps_nxt = steps;
      mode_nxt  = mode;
      case (state)
         IDLE: begin
            if (disp_rise) begin
               state_nxt = SPINUP;
               phase_nxt = '0;
               case (amount)
                  2'b01:   steps_nxt = 9'd200;
                  2'b10:   steps_nxt = 9'd300;
                  default: steps_nxt = 9'd100;
               endcase
            end else if (test != 3'b000 && test != 3'b111) begin
               state_nxt = TEST;
               phase_nxt = '0;
               mode_nxt  = test;
            end
         end
         SPINUP: begin
            if (phase == SPIN_LAST) begin
               state_nxt = STEP;
               phase_nxt = '0;
               pulse_nxt = '0;
            end else begin
               phase_nxt = phase + 16'd1;
            end
         end
         STEP: begin
            // A pulse counts once its low phase has finished.
            if (phase == LAST_N) begin
               phase_nxt = '0;
               if (pulse + 9'd1 == steps) state_nxt = DONE;
               else                       pulse_nxt = pulse + 9'd1;
            end else begin
               phase_nxt = phase + 16'd1;
            end
         end
         DONE: begin
            if (!disp) state_nxt = IDLE;
         end
         TEST: begin
            // Any change of test drops to IDLE for one cycle before re-entry.
            if (test != mode)            state_nxt = IDLE;
            else if (phase == test_last) phase_nxt = '0;
            else                         phase_nxt = phase + 16'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs align with it.
   always_comb begin
      duty_nxt = 8'd0;
      step_nxt = 1'b0;
      dir_nxt  = 1'b0;
      in1_nxt  = 1'b0;
      in2_nxt  = 1'b1;
      hs_nxt   = 1'b0;
      case (state_nxt)
         SPINUP: duty_nxt = 8'd128;
         STEP: begin
            duty_nxt = 8'd128;
            step_nxt = (phase_nxt < HALF_N);
         end
         DONE: hs_nxt = 1'b1;
         TEST: begin
            case (mode_nxt)
               3'b001: step_nxt = (phase_nxt < HALF_N);
               3'b010: begin
                  step_nxt = (phase_nxt < HALF_N);
                  dir_nxt  = 1'b1;
               end
               3'b011: step_nxt = (phase_nxt < HALF_F);
               3'b100: duty_nxt = 8'd64;
               3'b101: begin
                  duty_nxt = 8'd64;
                  in1_nxt  = 1'b1;
                  in2_nxt  = 1'b0;
               end
               3'b110: duty_nxt = 8'd192;
               default: duty_nxt = 8'd0;
            endcase
         end
         default: duty_nxt = 8'd0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         phase        <= '0;
         pulse        <= '0;
         steps        <= '0;
         mode         <= '0;
         disp_q       <= 1'b0;
         pwm_cnt      <= '0;
         handshake    <= 1'b0;
         busy         <= 1'b0;
         stepper_dir  <= 1'b0;
         stepper_step <= 1'b0;
         dc_pwm       <= 1'b0;
         dc_in1       <= 1'b0;
         dc_in2       <= 1'b1;
      end else begin
         state        <= state_nxt;
         phase        <= phase_nxt;
         pulse        <= pulse_nxt;
         steps        <= steps_nxt;
         mode         <= mode_nxt;
         disp_q       <= disp;
         pwm_cnt      <= pwm_cnt + 8'd1;
         handshake    <= hs_nxt;
         busy         <= (state_nxt != IDLE);
         stepper_dir  <= dir_nxt;
         stepper_step <= step_nxt;
         dc_pwm       <= (pwm_cnt < duty_nxt);
         dc_in1       <= in1_nxt;
         dc_in2       <= in2_nxt;
      end
   end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: timeline model of a dispense / test session
// checked every cycle, plus literal pulse and handshake counts.
module tb_dispense_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       disp;
   logic [1:0] amount;
   logic [2:0] test;
   logic       handshake, busy, stepper_dir, stepper_step, dc_pwm, dc_in1, dc_in2;
   logic [2:0] state_dbg;

   int total = 0;
   int bad   = 0;

   // Statistics over DUT outputs, sampled once per cycle.
   int   rises = 0, hs_cyc = 0, pwm_hi = 0, busy_nohs = 0, dir_bad = 0;
   logic prev_step = 1'b0, prev_dir = 1'b0;

   // Model: mode 0 idle, 1 dispense, 2 test; m_t = cycles since entry.
   int         m_mode, m_t, m_n, m_e;
   logic [2:0] m_tv;
   logic       m_prev, m_rise;

   dispense_sequencer #(
      .STEP_HALF(4), .STEP_HALF_FAST(2), .SPINUP_CYC(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .disp(disp), .amount(amount), .test(test),
      .handshake(handshake), .busy(busy), .stepper_dir(stepper_dir),
      .stepper_step(stepper_step), .dc_pwm(dc_pwm), .dc_in1(dc_in1),
      .dc_in2(dc_in2), .state_dbg(state_dbg)
   );

   // Clock.
   always #5 clk = ~clk;

   function automatic int steps_for(input logic [1:0] a);
      case (a)
         2'b01:   return 200;
         2'b10:   return 300;
         default: return 100;
      endcase
   endfunction

   // Model advance on every edge, from the inputs sampled at that edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_t = 0; m_n = 0; m_e = 0; m_tv = 3'b000; m_prev = 1'b0;
      end else begin
         m_rise = disp && !m_prev;
         m_prev = disp;
         m_e    = m_e + 1;
         case (m_mode)
            0: begin
               if (m_rise) begin
                  m_mode = 1; m_t = 1; m_n = steps_for(amount);
               end else if (test != 3'b000 && test != 3'b111) begin
                  m_mode = 2; m_t = 1; m_tv = test;
               end
            end
            1: begin
               if (m_t > 16 + 8 * m_n && !disp) m_mode = 0;
               else m_t = m_t + 1;
            end
            default: begin
               if (test != m_tv) m_mode = 0;
               else m_t = m_t + 1;
            end
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model, plus statistics.
   task automatic cycle_check();
      int e_busy, e_hs, e_step, e_dir, e_in1, e_in2, e_pwm, duty;
      e_busy = 0; e_hs = 0; e_step = 0; e_dir = 0; e_in1 = 0; e_in2 = 1; duty = 0;
      if (m_mode == 1) begin
         e_busy = 1;
         if (m_t <= 16) duty = 128;
         else if (m_t <= 16 + 8 * m_n) begin
            duty   = 128;
            e_step = (((m_t - 17) % 8) < 4) ? 1 : 0;
         end else e_hs = 1;
      end else if (m_mode == 2) begin
         e_busy = 1;
         case (m_tv)
            3'b001: e_step = (((m_t - 1) % 8) < 4) ? 1 : 0;
            3'b010: begin e_step = (((m_t - 1) % 8) < 4) ? 1 : 0; e_dir = 1; end
            3'b011: e_step = (((m_t - 1) % 4) < 2) ? 1 : 0;
            3'b100: duty = 64;
            3'b101: begin duty = 64; e_in1 = 1; e_in2 = 0; end
            3'b110: duty = 192;
            default: duty = 0;
         endcase
      end
      e_pwm = (duty != 0 && ((m_e - 1) % 256) < duty) ? 1 : 0;
      chk("busy", int'(busy), e_busy);
      chk("handshake", int'(handshake), e_hs);
      chk("stepper_step", int'(stepper_step), e_step);
      chk("stepper_dir", int'(stepper_dir), e_dir);
      chk("dc_in1", int'(dc_in1), e_in1);
      chk("dc_in2", int'(dc_in2), e_in2);
      chk("dc_pwm", int'(dc_pwm), e_pwm);
      if (stepper_step && !prev_step) rises = rises + 1;
      if (handshake) hs_cyc = hs_cyc + 1;
      if (busy && !handshake) busy_nohs = busy_nohs + 1;
      if (dc_pwm) pwm_hi = pwm_hi + 1;
      if (prev_step && stepper_step && stepper_dir != prev_dir) dir_bad = dir_bad + 1;
      prev_step = stepper_step;
      prev_dir  = stepper_dir;
   endtask

   // Advance n cycles, checking at each falling edge; inputs change afterwards.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         cycle_check();
      end
   endtask

   int s_r, s_h, s_p, s_b;

   task automatic snap();
      s_r = rises; s_h = hs_cyc; s_p = pwm_hi; s_b = busy_nohs;
   endtask

   initial begin
      rst_n = 1'b0; disp = 1'b0; amount = 2'b00; test = 3'b000;
      tick(3);
      // Reset state.
      chk("rst_busy", int'(busy), 0);
      chk("rst_handshake", int'(handshake), 0);
      chk("rst_step", int'(stepper_step), 0);
      chk("rst_dir", int'(stepper_dir), 0);
      chk("rst_pwm", int'(dc_pwm), 0);
      chk("rst_in1", int'(dc_in1), 0);
      chk("rst_in2", int'(dc_in2), 1);
      rst_n = 1'b1;
      tick(2);

      // 100-pulse dispense with disp held through DONE.
      snap();
      disp = 1'b1; amount = 2'b00;
      tick(1);
      chk("a_busy_latency", int'(busy), 1);
      tick(830);
      chk("a_pulses", rises - s_r, 100);
      chk("a_busy_cycles", busy_nohs - s_b, 816);
      chk("a_hs_held", int'(handshake), 1);
      chk("a_hs_cycles", hs_cyc - s_h, 15);
      disp = 1'b0;
      tick(1);
      chk("a_hs_drop", int'(handshake), 0);
      chk("a_idle", int'(busy), 0);
      tick(2);

      // 300-pulse dispense; amount changed and disp dropped mid-STEP.
      snap();
      amount = 2'b10; disp = 1'b1;
      tick(96);
      amount = 2'b00; disp = 1'b0;
      tick(2324);
      chk("b_pulses", rises - s_r, 300);
      chk("b_hs_cycles", hs_cyc - s_h, 1);
      chk("b_idle", int'(busy), 0);

      // Test 010 then 011: one idle cycle between, direction safe.
      snap();
      test = 3'b010;
      tick(40);
      chk("c_ccw_pulses", rises - s_r, 5);
      chk("c_ccw_dir", int'(stepper_dir), 1);
      test = 3'b011;
      tick(1);
      chk("c_gap_idle", int'(busy), 0);
      snap();
      tick(32);
      chk("c_fast_pulses", rises - s_r, 8);
      chk("c_fast_dir", int'(stepper_dir), 0);
      chk("c_dir_safe", dir_bad, 0);
      test = 3'b000;
      tick(3);

      // DC duty in test modes over a full PWM period.
      test = 3'b110;
      tick(1);
      snap();
      tick(256);
      chk("d_duty192", pwm_hi - s_p, 192);
      test = 3'b101;
      tick(2);
      snap();
      tick(256);
      chk("d_duty64", pwm_hi - s_p, 64);
      chk("d_in1_ccw", int'(dc_in1), 1);
      test = 3'b000;
      tick(3);

      // Reset in the middle of a 200-pulse dispense, then a full one.
      snap();
      amount = 2'b01; disp = 1'b1;
      tick(410);
      chk("e_mid_step", int'(busy), 1);
      #2;
      rst_n = 1'b0; disp = 1'b0;
      #1;
      chk("e_rst_busy", int'(busy), 0);
      chk("e_rst_step", int'(stepper_step), 0);
      chk("e_rst_pwm", int'(dc_pwm), 0);
      chk("e_rst_in2", int'(dc_in2), 1);
      tick(2);
      chk("e_no_hs", hs_cyc - s_h, 0);
      rst_n = 1'b1;
      tick(2);
      snap();
      disp = 1'b1;
      tick(1620);
      chk("e_pulses", rises - s_r, 200);
      chk("e_hs", int'(handshake), 1);
      disp = 1'b0;
      tick(2);

      // disp rise and test request together: dispense wins, TEST after.
      snap();
      amount = 2'b11; test = 3'b100; disp = 1'b1;
      tick(1);
      chk("f_busy", int'(busy), 1);
      tick(820);
      chk("f_pulses", rises - s_r, 100);
      chk("f_hs", int'(handshake), 1);
      disp = 1'b0;
      tick(1);
      chk("f_gap_idle", int'(busy), 0);
      tick(1);
      chk("f_test_entry", int'(busy), 1);
      tick(10);
      test = 3'b000;
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
